// File: rtl/add16u_eval_pkg.sv
// Shared types and default widths for the approximate-adder error monitors.
package add16u_eval_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int OPW_DEF   = 16;
  localparam int CNT_W_DEF = 24;
  // |error| fits in OPW+1 bits, so a full batch of worst-case errors fits here.
  localparam int SUM_W_DEF = OPW_DEF + 1 + CNT_W_DEF;

endpackage

// File: rtl/add16u_err_monitor_if.sv
// Sample stream from the approximate adder under test into the monitor.
interface add16u_err_monitor_if
  import add16u_eval_pkg::*;
#(
  parameter int OPW = OPW_DEF
) ();

  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] a;
  logic [OPW-1:0] b;
  logic [OPW:0]   approx_o;

  modport master (output in_valid, output a, output b, output approx_o, input in_ready);
  modport slave  (input in_valid, input a, input b, input approx_o, output in_ready);

endinterface

// File: rtl/add16u_err_stage.sv
// Combinational error stage: signed difference, magnitude and max compare.
module add16u_err_stage
  import add16u_eval_pkg::*;
#(
  parameter int OPW = OPW_DEF
) (
  input  logic [OPW:0] i_exact,
  input  logic [OPW:0] i_approx,
  input  logic [OPW:0] i_cur_max,
  output logic [OPW:0] o_abs_d,
  output logic         o_is_err,
  output logic         o_new_max
);

  // Magnitude of a difference of two OPW+1-bit unsigned values always fits OPW+1 bits.
  function automatic logic [OPW:0] abs_mag(input logic signed [OPW+1:0] d);
    logic signed [OPW+1:0] m;
    m = (d < 0) ? -d : d;
    return m[OPW:0];
  endfunction

  logic signed [OPW+1:0] w_diff;

  assign w_diff    = $signed({1'b0, i_exact}) - $signed({1'b0, i_approx});
  assign o_abs_d   = abs_mag(w_diff);
  assign o_is_err  = (o_abs_d != '0);
  // Strict compare so that ties keep the earliest worst case.
  assign o_new_max = (o_abs_d > i_cur_max);

endmodule

// File: rtl/add16u_err_monitor.sv
// Batch error-statistics engine for a 16-bit unsigned approximate adder.
module add16u_err_monitor
  import add16u_eval_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int OPW   = OPW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CNT_W-1:0]    cfg_n,
  add16u_err_monitor_if.slave s_in,
  output logic                busy,
  output logic                done,
  output logic [OPW+CNT_W:0]  sum_abs_err,
  output logic [OPW:0]        max_abs_err,
  output logic [OPW-1:0]      max_a,
  output logic [OPW-1:0]      max_b,
  output logic [CNT_W-1:0]    err_cnt,
  output logic [CNT_W-1:0]    smp_cnt
);

  localparam int SUM_W = OPW + 1 + CNT_W;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cfg_n, r_acc;
  logic               w_start_ok, w_ready, w_xfer;

  logic               r_vld_p1;
  logic [OPW:0]       r_exact_p1, r_approx_p1;
  logic [OPW-1:0]     r_a_p1, r_b_p1;

  logic [OPW:0]       w_abs_d;
  logic               w_is_err, w_new_max;

  logic [SUM_W-1:0]   r_sum;
  logic [OPW:0]       r_max;
  logic [OPW-1:0]     r_max_a, r_max_b;
  logic [CNT_W-1:0]   r_err_cnt, r_smp_cnt;

  // A start only counts when no batch is in flight.
  assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_ready    = (r_state == RUN) && (r_acc < r_cfg_n);
  assign w_xfer     = s_in.in_valid && w_ready;
  assign s_in.in_ready = w_ready;

  assign busy = (r_state == RUN) || (r_state == DRAIN);
  assign done = (r_state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: accept cfg_n samples, then let the pipeline empty.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (r_acc == r_cfg_n) w_next = DRAIN;
      DRAIN:   if (!r_vld_p1) w_next = DONE;
      DONE:    if (start) w_next = RUN;
      default: w_next = IDLE;
    endcase
  end

  // Batch length latch and accepted-sample counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg_n <= '0;
      r_acc   <= '0;
    end else if (w_start_ok) begin
      r_cfg_n <= cfg_n;
      r_acc   <= '0;
    end else if (w_xfer) begin
      r_acc   <= r_acc + CNT_W'(1);
    end
  end

  // ---- S1: exact sum and captured approximate result ----
  // S1 valid.
  always_ff @(posedge clk) begin
    if (rst) r_vld_p1 <= 1'b0;
    else     r_vld_p1 <= w_xfer;
  end

  // S1 data, loaded only on a transfer.
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_exact_p1  <= {1'b0, s_in.a} + {1'b0, s_in.b};
      r_approx_p1 <= s_in.approx_o;
      r_a_p1      <= s_in.a;
      r_b_p1      <= s_in.b;
    end
  end

  // ---- S2: error magnitude and statistics update ----
  add16u_err_stage #(.OPW(OPW)) u_err_stage (
    .i_exact   (r_exact_p1),
    .i_approx  (r_approx_p1),
    .i_cur_max (r_max),
    .o_abs_d   (w_abs_d),
    .o_is_err  (w_is_err),
    .o_new_max (w_new_max)
  );

  // Statistics accumulate every valid S2 sample; cleared by reset or an honoured start.
  always_ff @(posedge clk) begin
    if (rst || w_start_ok) begin
      r_sum     <= '0;
      r_max     <= '0;
      r_max_a   <= '0;
      r_max_b   <= '0;
      r_err_cnt <= '0;
      r_smp_cnt <= '0;
    end else if (r_vld_p1) begin
      r_sum     <= r_sum + SUM_W'(w_abs_d);
      r_err_cnt <= r_err_cnt + CNT_W'(w_is_err);
      r_smp_cnt <= r_smp_cnt + CNT_W'(1);
      if (w_new_max) begin
        r_max   <= w_abs_d;
        r_max_a <= r_a_p1;
        r_max_b <= r_b_p1;
      end
    end
  end

  assign sum_abs_err = r_sum;
  assign max_abs_err = r_max;
  assign max_a       = r_max_a;
  assign max_b       = r_max_b;
  assign err_cnt     = r_err_cnt;
  assign smp_cnt     = r_smp_cnt;

endmodule

// File: tb/tb_add16u_err_monitor.sv
// Directed bench for add16u_err_monitor: table of batches plus hand-written corner sequences.
module tb_add16u_err_monitor;
  import add16u_eval_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [CNT_W_DEF-1:0]  cfg_n;
  logic                  busy, done;
  logic [SUM_W_DEF-1:0]  sum_abs_err;
  logic [OPW_DEF:0]      max_abs_err;
  logic [OPW_DEF-1:0]    max_a, max_b;
  logic [CNT_W_DEF-1:0]  err_cnt, smp_cnt;

  add16u_err_monitor_if #(.OPW(OPW_DEF)) bus ();

  add16u_err_monitor #(.CNT_W(CNT_W_DEF), .OPW(OPW_DEF)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cfg_n       (cfg_n),
    .s_in        (bus),
    .busy        (busy),
    .done        (done),
    .sum_abs_err (sum_abs_err),
    .max_abs_err (max_abs_err),
    .max_a       (max_a),
    .max_b       (max_b),
    .err_cnt     (err_cnt),
    .smp_cnt     (smp_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] ap;
  } smp_t;

  typedef struct {
    int          first;
    int          n;
    logic [40:0] sum;
    logic [16:0] mx;
    logic [15:0] ma;
    logic [15:0] mb;
    int          ec;
    int          sc;
  } vec_t;

  smp_t smps[13];
  vec_t vecs[6];

  int n_chk  = 0;
  int n_pass = 0;
  int t_start = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic do_start(input logic [CNT_W_DEF-1:0] n);
    start = 1'b1;
    cfg_n = n;
    @(posedge clk); #1;
    start = 1'b0;
    t_start = cyc;
  endtask

  task automatic wait_done(output int lat);
    int k;
    k = 0;
    while (!done && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("done_seen", 64'(done), 64'd1);
    lat = cyc - t_start;
  endtask

  task automatic chk_stats(input string tag, input vec_t v);
    chk({tag, "_sum"},   64'(sum_abs_err), 64'(v.sum));
    chk({tag, "_max"},   64'(max_abs_err), 64'(v.mx));
    chk({tag, "_max_a"}, 64'(max_a),       64'(v.ma));
    chk({tag, "_max_b"}, 64'(max_b),       64'(v.mb));
    chk({tag, "_err"},   64'(err_cnt),     64'(v.ec));
    chk({tag, "_smp"},   64'(smp_cnt),     64'(v.sc));
  endtask

  // Start a batch, stream its samples with in_valid held high, then check timing and stats.
  task automatic run_vec(input vec_t v, input string tag);
    int i, k, lat;
    do_start(CNT_W_DEF'(v.n));
    i = 0;
    k = 0;
    while (i < v.n && k < 100) begin
      bus.a        = smps[v.first + i].a;
      bus.b        = smps[v.first + i].b;
      bus.approx_o = smps[v.first + i].ap;
      bus.in_valid = 1'b1;
      if (bus.in_ready) i++;
      @(posedge clk); #1;
      k++;
    end
    bus.in_valid = 1'b0;
    chk({tag, "_xfers"}, 64'(i), 64'(v.n));
    wait_done(lat);
    chk({tag, "_done_lat"}, 64'(lat), 64'(v.n + 2));
    chk_stats(tag, v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lat, i, k, extra;
    logic rdy_seen, pulsed;
    vec_t z;

    smps[0]  = '{16'd0,     16'd0,     17'h00050};
    smps[1]  = '{16'd1,     16'd2,     17'd3};
    smps[2]  = '{16'hFFFF,  16'hFFFF,  17'h1FFFE};
    smps[3]  = '{16'd10,    16'd10,    17'd25};
    smps[4]  = '{16'd100,   16'd200,   17'd307};
    smps[5]  = '{16'd5,     16'd6,     17'd4};
    smps[6]  = '{16'd0,     16'd0,     17'd0};
    smps[7]  = '{16'd1000,  16'd1000,  17'd2003};
    smps[8]  = '{16'hFFFF,  16'd0,     17'd0};
    smps[9]  = '{16'd2,     16'd2,     17'd1};
    smps[10] = '{16'd0,     16'd0,     17'h1FFFF};
    smps[11] = '{16'hFFFF,  16'hFFFF,  17'd0};
    smps[12] = '{16'd7,     16'd8,     17'd16};

    //            first n  sum          max          max_a     max_b     err sc
    vecs[0] = '{0,  1, 41'd80,     17'd80,     16'd0,    16'd0,    1, 1};
    vecs[1] = '{1,  3, 41'd5,      17'd5,      16'd10,   16'd10,   1, 3};
    vecs[2] = '{4,  2, 41'd14,     17'd7,      16'd100,  16'd200,  2, 2};
    vecs[3] = '{6,  4, 41'd65541,  17'd65535,  16'hFFFF, 16'd0,    3, 4};
    vecs[4] = '{10, 2, 41'd262141, 17'd131071, 16'd0,    16'd0,    2, 2};
    vecs[5] = '{12, 1, 41'd1,      17'd1,      16'd7,    16'd8,    1, 1};
    z       = '{0,  0, 41'd0,      17'd0,      16'd0,    16'd0,    0, 0};

    rst = 1'b1;
    start = 1'b0;
    cfg_n = '0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.approx_o = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  64'(busy),         64'd0);
    chk("rst_done",  64'(done),         64'd0);
    chk("rst_ready", 64'(bus.in_ready), 64'd0);
    chk_stats("rst", z);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

    // Empty batch: never ready, done two cycles after start, stats cleared.
    do_start('0);
    chk("n0_busy", 64'(busy), 64'd1);
    chk("n0_done_drop", 64'(done), 64'd0);
    bus.in_valid = 1'b1;
    rdy_seen = 1'b0;
    for (int c = 0; c < 2; c++) begin
      rdy_seen = rdy_seen | bus.in_ready;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("n0_ready_never", 64'(rdy_seen), 64'd0);
    chk("n0_done_lat", 64'(done), 64'd1);
    chk_stats("n0", z);

    // Random in_valid, a start pulse mid-batch that must be ignored.
    do_start(CNT_W_DEF'(4));
    i = 0;
    k = 0;
    pulsed = 1'b0;
    while (i < 4 && k < 200) begin
      bus.a        = 16'(i + 1);
      bus.b        = 16'(i + 1);
      bus.approx_o = 17'(2 * i + 3);
      bus.in_valid = ($urandom_range(0, 1) == 1);
      if (i == 2 && !pulsed) begin
        start  = 1'b1;
        cfg_n  = CNT_W_DEF'(9);
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) i++;
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    chk("rnd_ready_after_last", 64'(bus.in_ready), 64'd0);
    extra = 0;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (bus.in_ready) extra++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("rnd_xfers", 64'(i + extra), 64'd4);
    wait_done(lat);
    chk_stats("rnd", '{0, 4, 41'd4, 17'd1, 16'd1, 16'd1, 4, 4});

    // Reset in the middle of a batch.
    do_start(CNT_W_DEF'(5));
    i = 0;
    k = 0;
    while (i < 2 && k < 50) begin
      bus.a        = 16'd100;
      bus.b        = 16'd100;
      bus.approx_o = 17'd0;
      bus.in_valid = 1'b1;
      if (bus.in_ready) i++;
      @(posedge clk); #1;
      k++;
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_busy",  64'(busy),         64'd0);
    chk("mid_rst_done",  64'(done),         64'd0);
    chk("mid_rst_ready", 64'(bus.in_ready), 64'd0);
    chk_stats("mid_rst", z);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_smp", 64'(smp_cnt), 64'd0);
    chk("post_rst_sum", 64'(sum_abs_err), 64'd0);
    run_vec(vecs[5], "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
